hamming_accum: RTL

Serial Hamming-distance accumulator placed directly downstream of the XOR gate. Each accepted `in_bit` is one XOR result (a ≠ b for one bit position). After `FRAME_LEN` accepted bits the block emits the frame's bit-difference count and parity on a valid/ready output, then starts the next frame. It turns the XOR's per-bit difference stream into per-word distance results.

---
 rtl/hamming_accum_pkg.sv | 12 +
 rtl/hamming_accum.sv | 109 ++++++++++
 2 files changed

// File: rtl/hamming_accum_pkg.sv
// Shared types and default constants for the serial Hamming-distance accumulator.
package hamming_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } hs_state_t;

  localparam int unsigned HAMMING_FRAME_LEN_DEF = 8;
  localparam int unsigned HAMMING_THRESH_DEF    = 2;

endpackage

// File: rtl/hamming_accum.sv
// Counts ones in each FRAME_LEN-bit frame of an XOR difference stream and emits distance/parity.
// Optional distance-threshold flag out_err is built when HAMMING_THRESH_EN is defined.
module hamming_accum
  import hamming_pkg::*;
#(
  parameter int unsigned FRAME_LEN = HAMMING_FRAME_LEN_DEF,
  parameter int unsigned CNT_W     = $clog2(FRAME_LEN + 1)
`ifdef HAMMING_THRESH_EN
  ,
  parameter int unsigned THRESH    = HAMMING_THRESH_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_dist,
  output logic             out_parity
`ifdef HAMMING_THRESH_EN
  ,
  output logic             out_err
`endif
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  hs_state_t        state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             par_q, par_d;
  logic [CNT_W-1:0] dist_q, dist_d;
  logic             parity_q, parity_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] acc_sum;

  assign acc_sum = acc_q + CNT_W'(in_bit);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    par_d    = par_q;
    dist_d   = dist_q;
    parity_d = parity_q;
    err_d    = err_q;
    unique case (state_q)
      ACCUM: begin
        if (in_valid) begin
          if (idx_q == LAST_IDX) begin
            // Final bit folds straight into the result registers; running state clears.
            state_d  = HOLD;
            dist_d   = acc_sum;
            parity_d = par_q ^ in_bit;
`ifdef HAMMING_THRESH_EN
            err_d    = 32'(acc_sum) > THRESH;
`endif
            idx_d    = '0;
            acc_d    = '0;
            par_d    = 1'b0;
          end else begin
            idx_d = idx_q + CNT_W'(1);
            acc_d = acc_sum;
            par_d = par_q ^ in_bit;
          end
        end
      end
      HOLD: begin
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ACCUM;
      idx_q    <= '0;
      acc_q    <= '0;
      par_q    <= 1'b0;
      dist_q   <= '0;
      parity_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      par_q    <= par_d;
      dist_q   <= dist_d;
      parity_q <= parity_d;
      err_q    <= err_d;
    end
  end

  assign in_ready   = (state_q == ACCUM);
  assign out_valid  = (state_q == HOLD);
  assign out_dist   = dist_q;
  assign out_parity = parity_q;

`ifdef HAMMING_THRESH_EN
  assign out_err = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule
